// File: rtl/uart_adc_framer_if.sv
// UART transmit-side handshake between the ADC framer and the transmitter.
// The framer is the master: it drives the load strobe, the byte and the enable.
interface uart_adc_framer_if;
  logic       tx_empty;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;

  modport master (
    input  tx_empty,
    output ld_tx_data,
    output tx_data,
    output tx_enable
  );

  modport slave (
    output tx_empty,
    input  ld_tx_data,
    input  tx_data,
    input  tx_enable
  );
endinterface

// File: rtl/uart_adc_framer.sv
// Snapshots NUM_CH ADC words on start and streams them to a UART,
// as raw bytes or uppercase ASCII hex, with separator and terminator bytes.
module uart_adc_framer #(
  parameter int         NUM_CH    = 4,
  parameter int         CH_WIDTH  = 32,
  parameter logic [7:0] SEP_BYTE  = 8'h2C,
  parameter logic [7:0] TERM_BYTE = 8'h0A
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ascii_mode,
  input  logic [NUM_CH*CH_WIDTH-1:0] adc_data,
  output logic                       busy,
  output logic                       frame_done,
  uart_adc_framer_if.master          tx
);

  localparam int DW  = NUM_CH * CH_WIDTH;
  localparam int BPC = CH_WIDTH / 8;
  localparam int NIB = CH_WIDTH / 4;
  localparam int CHB = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IXB = $clog2(NIB + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    SETTLE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    snap_q, snap_d;
  logic             mode_q, mode_d;
  logic [CHB-1:0]   ch_q, ch_d;
  logic [IXB-1:0]   idx_q, idx_d;
  logic             ld_q, ld_d;
  logic [7:0]       data_q, data_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  int               per;
  logic             last;

  // Index i == digits-per-channel selects the separator/terminator slot.
  function automatic logic [7:0] byte_at(
    input logic [DW-1:0] d,
    input logic          m,
    input int            c,
    input int            i
  );
    logic [CH_WIDTH-1:0] w;
    logic [3:0]          n;
    byte_at = 8'h00;
    w = d[c*CH_WIDTH +: CH_WIDTH];
    n = 4'h0;
    if (i >= (m ? NIB : BPC)) begin
      byte_at = (c == NUM_CH - 1) ? TERM_BYTE : SEP_BYTE;
    end else if (m) begin
      n = w[CH_WIDTH-4-4*i +: 4];
      byte_at = (n < 4'd10) ? (8'h30 + {4'h0, n})
                            : (8'h37 + {4'h0, n});
    end else begin
      byte_at = w[CH_WIDTH-8-8*i +: 8];
    end
  endfunction

  assign per  = mode_q ? NIB : BPC;
  assign last = (int'(idx_q) == per) &&
                (int'(ch_q) == NUM_CH - 1);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    ld_d    = ld_q;
    data_d  = data_q;
    en_d    = en_q;
    busy_d  = busy_q;
    fd_d    = fd_q;
    unique case (state_q)
      IDLE: begin
        fd_d = 1'b0;
        if (start) begin
          state_d = WAIT_RDY;
          snap_d  = adc_data;
          mode_d  = ascii_mode;
          ch_d    = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          data_d  = byte_at(adc_data, ascii_mode, 0, 0);
        end
      end
      WAIT_RDY: begin
        if (tx.tx_empty) begin
          state_d = LOAD;
          ld_d    = 1'b1;
        end
      end
      LOAD: begin
        ld_d    = 1'b0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (last) begin
          state_d = DONE;
          fd_d    = 1'b1;
          busy_d  = 1'b0;
          en_d    = 1'b0;
        end else begin
          if (int'(idx_q) == per) begin
            ch_d  = ch_q + CHB'(1);
            idx_d = '0;
          end else begin
            idx_d = idx_q + IXB'(1);
          end
          data_d  = byte_at(snap_q, mode_q,
                            int'(ch_d), int'(idx_d));
          state_d = WAIT_RDY;
        end
      end
      DONE: begin
        fd_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      mode_q  <= 1'b0;
      ch_q    <= '0;
      idx_q   <= '0;
      ld_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      ld_q    <= ld_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
    end
  end

  assign tx.ld_tx_data = ld_q;
  assign tx.tx_data    = data_q;
  assign tx.tx_enable  = en_q;
  assign busy          = busy_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_uart_adc_framer.sv
// Bench for uart_adc_framer: directed frames on a 2x16 and a 4x32 instance,
// then random frames checked against a byte-list reference model.
module tb_uart_adc_framer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start_s = 1'b0;
  logic         start_d = 1'b0;
  logic         ascii_mode = 1'b0;
  logic         tx_empty = 1'b1;
  logic [31:0]  adc_s = '0;
  logic [127:0] adc_d = '0;
  logic         busy_s, fd_s, busy_d, fd_d;

  uart_adc_framer_if ifs ();
  uart_adc_framer_if ifd ();

  assign ifs.tx_empty = tx_empty;
  assign ifd.tx_empty = tx_empty;

  uart_adc_framer #(.NUM_CH(2), .CH_WIDTH(16)) dut_s (
    .clock      (clock),
    .reset      (reset),
    .start      (start_s),
    .ascii_mode (ascii_mode),
    .adc_data   (adc_s),
    .busy       (busy_s),
    .frame_done (fd_s),
    .tx         (ifs.master)
  );

  uart_adc_framer dut_d (
    .clock      (clock),
    .reset      (reset),
    .start      (start_d),
    .ascii_mode (ascii_mode),
    .adc_data   (adc_d),
    .busy       (busy_d),
    .frame_done (fd_d),
    .tx         (ifd.master)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int         gcyc_q[$];
  logic [7:0] exp_q[$];
  int         fd_cnt = 0;
  int         fd0 = 0;
  int         st = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  always @(negedge clock) begin
    if (ifs.ld_tx_data) begin
      got_q.push_back(ifs.tx_data);
      gcyc_q.push_back(cyc);
    end
    if (ifd.ld_tx_data) begin
      got_q.push_back(ifd.tx_data);
      gcyc_q.push_back(cyc);
    end
    fd_cnt <= fd_cnt + (fd_s ? 1 : 0) + (fd_d ? 1 : 0);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Expected frame as a plain list of characters/bytes.
  function automatic void model(input logic [127:0] d, input bit m,
                                input int nch, input int w);
    logic [127:0] word;
    int           n;
    exp_q.delete();
    for (int c = 0; c < nch; c++) begin
      word = (d >> (c * w)) & ((128'd1 << w) - 128'd1);
      if (m) begin
        for (int k = w / 4 - 1; k >= 0; k--) begin
          n = int'((word >> (4 * k)) & 128'hF);
          exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
        end
      end else begin
        for (int k = w / 8 - 1; k >= 0; k--)
          exp_q.push_back(8'((word >> (8 * k)) & 128'hFF));
      end
      exp_q.push_back(c == nch - 1 ? 8'h0A : 8'h2C);
    end
  endfunction

  task automatic pulse(input bit big);
    @(posedge clock);
    #1;
    got_q.delete();
    gcyc_q.delete();
    fd0 = fd_cnt;
    st  = cyc;
    if (big) start_d = 1'b1;
    else start_s = 1'b1;
    @(posedge clock);
    #1;
    start_s = 1'b0;
    start_d = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      if (got_q.size() >= n) break;
    end
    chk("strobe_wait", 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic wait_frame(input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      if (fd_cnt != fd0) begin
        done = 1'b1;
        break;
      end
      if (rnd) begin
        #1;
        tx_empty = 1'($urandom_range(0, 1));
      end
    end
    #1;
    tx_empty = 1'b1;
    chk("frame_end", 64'(done), 64'd1);
  endtask

  task automatic check_frame(input string tag, input bit timing,
                             input bit big);
    int n;
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      if (timing)
        chk($sformatf("%s_cyc%0d", tag, i),
            64'(gcyc_q[i]), 64'(st + 2 + 3 * i));
    end
    chk({tag, "_fdone"}, 64'(fd_cnt - fd0), 64'd1);
    chk({tag, "_idle"}, 64'(big ? busy_d : busy_s), 64'd0);
  endtask

  task automatic check_zero_outs(input string tag);
    chk({tag, "_ld"}, 64'(ifs.ld_tx_data), 64'd0);
    chk({tag, "_data"}, 64'(ifs.tx_data), 64'd0);
    chk({tag, "_en"}, 64'(ifs.tx_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy_s), 64'd0);
    chk({tag, "_fd"}, 64'(fd_s), 64'd0);
  endtask

  initial begin
    int bad;
    int seen;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_zero_outs("rst");
    reset = 1'b0;

    adc_s = {16'hBEEF, 16'h1234};
    ascii_mode = 1'b0;
    pulse(1'b0);
    chk("bin_busy", 64'(busy_s), 64'd1);
    chk("bin_en", 64'(ifs.tx_enable), 64'd1);
    wait_frame(1'b0);
    exp_q = '{8'h12, 8'h34, 8'h2C, 8'hBE, 8'hEF, 8'h0A};
    check_frame("bin", 1'b1, 1'b0);

    ascii_mode = 1'b1;
    pulse(1'b0);
    wait_frame(1'b0);
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h2C,
              8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    check_frame("asc", 1'b1, 1'b0);

    pulse(1'b0);
    wait_strobes(2);
    #1;
    tx_empty = 1'b0;
    @(posedge clock);
    bad = 0;
    seen = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clock);
      if (ifs.ld_tx_data) seen++;
      if (ifs.tx_data !== 8'h33 || busy_s !== 1'b1) bad++;
    end
    chk("stall_ld", 64'(seen), 64'd0);
    chk("stall_hold", 64'(bad), 64'd0);
    @(posedge clock);
    #1;
    tx_empty = 1'b1;
    wait_frame(1'b0);
    check_frame("stall", 1'b0, 1'b0);

    ascii_mode = 1'b0;
    pulse(1'b0);
    wait_strobes(2);
    #1;
    start_s = 1'b1;
    adc_s = $urandom;
    repeat (3) @(posedge clock);
    #1;
    start_s = 1'b0;
    wait_frame(1'b0);
    exp_q = '{8'h12, 8'h34, 8'h2C, 8'hBE, 8'hEF, 8'h0A};
    check_frame("restart", 1'b1, 1'b0);
    repeat (6) @(posedge clock);
    chk("restart_quiet", 64'(got_q.size()), 64'd6);

    adc_s = {16'hBEEF, 16'h1234};
    pulse(1'b0);
    wait_strobes(2);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_zero_outs("abort");
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    chk("abort_quiet", 64'(got_q.size()), 64'd2);
    pulse(1'b0);
    wait_frame(1'b0);
    exp_q = '{8'h12, 8'h34, 8'h2C, 8'hBE, 8'hEF, 8'h0A};
    check_frame("rearm", 1'b1, 1'b0);

    ascii_mode = 1'b1;
    adc_d = '0;
    pulse(1'b1);
    wait_frame(1'b0);
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 8; k++) exp_q.push_back(8'h30);
      exp_q.push_back(c == 3 ? 8'h0A : 8'h2C);
    end
    check_frame("zero36", 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      adc_s = $urandom;
      ascii_mode = 1'($urandom_range(0, 1));
      pulse(1'b0);
      wait_frame(1'b1);
      model({96'h0, adc_s}, ascii_mode, 2, 16);
      check_frame($sformatf("rnd_s%0d", r), 1'b0, 1'b0);
    end

    for (int r = 0; r < 2; r++) begin
      adc_d = {$urandom, $urandom, $urandom, $urandom};
      ascii_mode = 1'($urandom_range(0, 1));
      pulse(1'b1);
      wait_frame(1'b1);
      model(adc_d, ascii_mode, 4, 32);
      check_frame($sformatf("rnd_d%0d", r), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_adc_framer.md
Name: uart_adc_framer

Overview:
Parametrised successor to the single-byte UART control FSM. On a start pulse it snapshots NUM_CH ADC channel words and streams them to the UART transmitter byte by byte, in either raw binary or ASCII-hex form. Channels are separated by SEP_BYTE and each frame ends with TERM_BYTE. Flow control uses the transmitter's tx_empty flag instead of a fixed cycle count.

Parameters:
NUM_CH, 4, number of ADC channels per frame (1..16)
CH_WIDTH, 32, bits per channel; must be a multiple of 8
SEP_BYTE, 8'h2C, separator sent after every channel except the last (',')
TERM_BYTE, 8'h0A, terminator sent after the last channel ('\n')

Ports:
clock  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  frame request; sampled only in IDLE
ascii_mode  input  1  1 = ASCII hex digits, 0 = raw binary bytes; latched at start
adc_data  input  NUM_CH*CH_WIDTH  channel ch occupies bits [ch*CH_WIDTH +: CH_WIDTH]
tx_empty  input  1  high when the UART transmitter can accept a byte
ld_tx_data  output  1  one-cycle load strobe to the UART
tx_data  output  8  byte presented to the UART
tx_enable  output  1  UART enable; high while busy
busy  output  1  high from the start acceptance through the terminator handshake
frame_done  output  1  one-cycle pulse after the terminator is loaded

Behaviour:
- Reset: ld_tx_data=0, tx_data=8'h00, tx_enable=0, busy=0, frame_done=0; state=IDLE; counters cleared. Reset mid-frame aborts the frame immediately; no further bytes are loaded.
- States: IDLE, WAIT_RDY, LOAD, SETTLE, DONE.
- IDLE: when start=1, latch adc_data and ascii_mode into a snapshot register, clear the channel and nibble/byte counters, and go to WAIT_RDY. busy and tx_enable go high on the next cycle. start in any other state is ignored; no queueing.
- WAIT_RDY: tx_data is driven with the current byte. When tx_empty=1, go to LOAD.
- LOAD: ld_tx_data=1 for exactly one cycle, with tx_data stable in this cycle and the cycle before. Then go to SETTLE.
- SETTLE: one cycle in which tx_empty is ignored, covering the UART's flag latency. Advance the byte pointer, then go to WAIT_RDY, or go to DONE if the byte just loaded was the TERM_BYTE.
- DONE: frame_done=1 for one cycle; busy, tx_enable and ld_tx_data are cleared; return to IDLE. A start arriving in DONE is ignored.
- Byte order per channel: channel 0 first, MSB first within each channel.
- Binary mode: CH_WIDTH/8 data bytes per channel.
- ASCII mode: CH_WIDTH/4 digits per channel. Nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h41+(n-10), i.e. uppercase.
- After each data run, send SEP_BYTE if ch < NUM_CH-1, otherwise TERM_BYTE.
- Frame length: binary = NUM_CH*(CH_WIDTH/8 + 1) bytes; ASCII = NUM_CH*(CH_WIDTH/4 + 1) bytes.
- Latency: with tx_empty held at 1, start in cycle N gives the first ld_tx_data in cycle N+2. Subsequent strobes follow every 3 cycles (WAIT_RDY, LOAD, SETTLE).
- Changes to adc_data while busy have no effect on the frame in progress.
- tx_empty held low stalls the block indefinitely in WAIT_RDY, holding tx_data and busy.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- NUM_CH=2, CH_WIDTH=16, adc_data={16'hBEEF,16'h1234}, ascii_mode=0, tx_empty=1, start pulse -> strobed bytes 12 34 2C BE EF 0A; first strobe 2 cycles after start, then a strobe every 3 cycles; frame_done pulses once; busy is low afterwards.
- Same data, ascii_mode=1 -> bytes 31 32 33 34 2C 42 45 45 46 0A; nibble values A-F map to uppercase 41-46.
- Same data and mode, tx_empty forced low for 20 cycles before the 3rd byte -> no strobe during the stall; tx_data held at 33; the remaining sequence is unchanged.
- start re-pulsed mid-frame, and adc_data changed mid-frame -> output identical to the first scenario; exactly one frame_done.
- reset asserted after the 2nd strobe -> all outputs 0 on the next cycle and no further strobes. A new start then produces a complete frame beginning with byte 12.
- Default parameters (4x32), ascii_mode=1, adc_data=128'h0 -> 36 strobes: 8x30, 2C repeated for the first three channels, then 8x30, 0A.
